// File: rtl/rv32_debug_loader.sv
// rv32_debug_loader: decodes a host byte stream into load/run commands and
// writes words into instruction or data RAM through the core's debug ports.
// Optional read-back verification of every written word: define LOADER_VERIFY_EN.
module rv32_debug_loader #(
  parameter int MAX_WORDS = 4096,
  parameter int ADDR_W    = 32
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] inst_a2,
  output logic [31:0]       inst_wd2,
  output logic [3:0]        inst_we2,
  input  logic [31:0]       inst_rd2,
  output logic [ADDR_W-1:0] data_a2,
  output logic [31:0]       data_wd2,
  output logic [3:0]        data_we2,
  input  logic [31:0]       data_rd2,
  output logic              core_hold,
  output logic              busy,
  output logic              err,
  output logic [15:0]       words_written
);

  localparam logic [7:0]        CMD_CLEAR    = 8'h00;
  localparam logic [7:0]        CMD_LOAD_I   = 8'h01;
  localparam logic [7:0]        CMD_LOAD_D   = 8'h02;
  localparam logic [7:0]        CMD_RUN      = 8'h03;
  localparam logic [31:0]       LP_MAX_WORDS = 32'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] LP_WORD_STEP = ADDR_W'(4);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_LEN, S_DATA, S_WRITE, S_VHOLD, S_VCMP
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_started;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_hdr_addr;
  logic [7:0]        r_count_lo;
  logic [15:0]       r_words_left;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_word;
  logic              r_sel_data;
  logic              r_busy;
  logic              r_err;
  logic              r_core_hold;
  logic [15:0]       r_words_written;

  logic              w_xfer;
  logic [15:0]       w_count;
  logic              w_hdr_bad;
  logic              w_last;
  logic              w_mismatch;
  logic              w_word_done;
  logic [ADDR_W-1:0] w_base;

`ifdef LOADER_VERIFY_EN
  localparam bit LP_VERIFY = 1'b1;
  assign w_mismatch = ((r_sel_data ? data_rd2 : inst_rd2) != r_word);
`else
  localparam bit LP_VERIFY = 1'b0;
  logic w_unused_rd;
  assign w_unused_rd = ^{inst_rd2, data_rd2};
  assign w_mismatch  = 1'b0;
`endif

  // Bytes are only taken in the header/data collecting states, and never in the reset cycle.
  assign in_ready = r_started &&
                    (r_state == S_CMD || r_state == S_ADDR || r_state == S_LEN || r_state == S_DATA);
  assign w_xfer   = in_valid && in_ready;

  // Count arrives low byte first; the high byte is the one on the bus at the end of LEN.
  assign w_count   = {in_data, r_count_lo};
  assign w_hdr_bad = (r_hdr_addr[1:0] != 2'b00) || ({16'd0, w_count} > LP_MAX_WORDS);
  assign w_last    = (r_words_left == 16'd1);
  assign w_base    = r_hdr_addr[ADDR_W-1:0];
  // A word is finished after its write, or after a successful readback when verifying.
  assign w_word_done = ((r_state == S_WRITE) && !LP_VERIFY) ||
                       ((r_state == S_VCMP) && !w_mismatch);

  // Both debug ports share the address/data registers; only the write enable selects the RAM.
  assign inst_a2       = r_wr_addr;
  assign data_a2       = r_wr_addr;
  assign inst_wd2      = r_word;
  assign data_wd2      = r_word;
  assign core_hold     = r_core_hold;
  assign busy          = r_busy;
  assign err           = r_err;
  assign words_written = r_words_written;

  // State register.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) r_state <= S_CMD;
    else         r_state <= w_state_next;
  end

  // Next-state decode and the single-cycle write enable pulse.
  always_comb begin
    w_state_next = r_state;
    inst_we2     = 4'h0;
    data_we2     = 4'h0;
    case (r_state)
      S_CMD:   if (w_xfer && (in_data == CMD_LOAD_I || in_data == CMD_LOAD_D)) w_state_next = S_ADDR;
      S_ADDR:  if (w_xfer && r_byte_cnt == 2'd3) w_state_next = S_LEN;
      S_LEN:   if (w_xfer && r_byte_cnt == 2'd1)
                 w_state_next = (w_hdr_bad || w_count == 16'd0) ? S_CMD : S_DATA;
      S_DATA:  if (w_xfer && r_byte_cnt == 2'd3) w_state_next = S_WRITE;
      S_WRITE: begin
        if (r_sel_data) data_we2 = 4'hF;
        else            inst_we2 = 4'hF;
        if (LP_VERIFY) w_state_next = S_VHOLD;
        else           w_state_next = w_last ? S_CMD : S_DATA;
      end
      S_VHOLD: w_state_next = S_VCMP;
      S_VCMP:  w_state_next = (w_mismatch || w_last) ? S_CMD : S_DATA;
      default: w_state_next = S_CMD;
    endcase
  end

  // Header capture, word assembly, address stepping and status flags.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      r_started       <= 1'b0;
      r_byte_cnt      <= 2'd0;
      r_hdr_addr      <= 32'd0;
      r_count_lo      <= 8'd0;
      r_words_left    <= 16'd0;
      r_wr_addr       <= '0;
      r_word          <= 32'd0;
      r_sel_data      <= 1'b0;
      r_busy          <= 1'b0;
      r_err           <= 1'b0;
      r_core_hold     <= 1'b1;
      r_words_written <= 16'd0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        S_CMD: if (w_xfer) begin
          r_byte_cnt <= 2'd0;
          case (in_data)
            CMD_CLEAR: r_err <= 1'b0;
            CMD_LOAD_I, CMD_LOAD_D: begin
              r_sel_data      <= (in_data == CMD_LOAD_D);
              r_busy          <= 1'b1;
              r_core_hold     <= 1'b1;
              r_words_written <= 16'd0;
            end
            CMD_RUN:   r_core_hold <= 1'b0;
            default:   r_err <= 1'b1;
          endcase
        end
        S_ADDR: if (w_xfer) begin
          r_hdr_addr <= {in_data, r_hdr_addr[31:8]};
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
        S_LEN: if (w_xfer) begin
          if (r_byte_cnt == 2'd0) begin
            r_count_lo <= in_data;
            r_byte_cnt <= 2'd1;
          end else begin
            r_byte_cnt   <= 2'd0;
            r_words_left <= w_count;
            r_wr_addr    <= w_base;
            if (w_hdr_bad) begin
              r_err  <= 1'b1;
              r_busy <= 1'b0;
            end else if (w_count == 16'd0) begin
              r_busy <= 1'b0;
            end
          end
        end
        S_DATA: if (w_xfer) begin
          r_word     <= {in_data, r_word[31:8]};
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
        S_WRITE: if (r_words_written != 16'hFFFF) r_words_written <= r_words_written + 16'd1;
        S_VCMP: if (w_mismatch) begin
          r_err  <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
      if (w_word_done) begin
        r_words_left <= r_words_left - 16'd1;
        r_wr_addr    <= r_wr_addr + LP_WORD_STEP;
        if (w_last) r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_debug_loader.sv
// tb_rv32_debug_loader: table vectors, hand-written corner sequences and a
// randomized packet stream checked against a packet-level reference model.
module tb_rv32_debug_loader;

  localparam int MAXW = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [31:0] inst_a2, inst_wd2, inst_rd2, data_a2, data_wd2, data_rd2;
  logic [3:0]  inst_we2, data_we2;
  logic        core_hold, busy, err;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  rv32_debug_loader #(.MAX_WORDS(MAXW), .ADDR_W(32)) dut (
    .CPU_CLK(clk), .CPU_RST(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .inst_a2(inst_a2), .inst_wd2(inst_wd2), .inst_we2(inst_we2), .inst_rd2(inst_rd2),
    .data_a2(data_a2), .data_wd2(data_wd2), .data_we2(data_we2), .data_rd2(data_rd2),
    .core_hold(core_hold), .busy(busy), .err(err), .words_written(words_written)
  );

  // RAM models with 1-cycle synchronous read; corrupt flips bit 0 of read data.
  logic [31:0] ram_i [0:1023];
  logic [31:0] ram_d [0:1023];
  bit corrupt = 1'b0;
  always @(posedge clk) begin
    inst_rd2 <= ram_i[inst_a2[11:2]] ^ {31'd0, corrupt};
    data_rd2 <= ram_d[data_a2[11:2]] ^ {31'd0, corrupt};
    if (inst_we2 == 4'hF) ram_i[inst_a2[11:2]] <= inst_wd2;
    if (data_we2 == 4'hF) ram_d[data_a2[11:2]] <= data_wd2;
  end

  typedef struct {
    logic        is_data;
    logic [3:0]  we;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t wlog[$];
  wr_t exp_q[$];

  // Write monitor: every cycle with a nonzero enable is one logged write.
  always @(negedge clk) begin
    if (inst_we2 != 4'h0) wlog.push_back('{1'b0, inst_we2, inst_a2, inst_wd2});
    if (data_we2 != 4'h0) wlog.push_back('{1'b1, data_we2, data_a2, data_wd2});
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    k = 0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || in_ready !== 1'b1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 100) $display("FAIL idle_timeout: busy=%b in_ready=%b, required busy=0 in_ready=1", busy, in_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  // Compare logged writes and status against expectations, then clear both logs.
  task automatic compare_state(input string nm, input logic e_err, input logic e_hold, input logic [15:0] e_ww);
    wait_idle();
    chk({nm, ".nwrites"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      chk({nm, ".port"}, {31'd0, wlog[i].is_data}, {31'd0, exp_q[i].is_data});
      chk({nm, ".we"},   {28'd0, wlog[i].we},      {28'd0, exp_q[i].we});
      chk({nm, ".addr"}, wlog[i].a, exp_q[i].a);
      chk({nm, ".data"}, wlog[i].d, exp_q[i].d);
    end
    chk({nm, ".err"},       {31'd0, err},       {31'd0, e_err});
    chk({nm, ".core_hold"}, {31'd0, core_hold}, {31'd0, e_hold});
    chk({nm, ".words"},     {16'd0, words_written}, {16'd0, e_ww});
    chk({nm, ".busy"},      {31'd0, busy},      32'd0);
    chk({nm, ".in_ready"},  {31'd0, in_ready},  32'd1);
    $display("txn %s: writes=%0d err=%b hold=%b words=%0d", nm, wlog.size(), err, core_hold, words_written);
    wlog.delete();
    exp_q.delete();
  endtask

  typedef struct {
    string        name;
    int           n;
    logic [127:0] b;
    int           nw;
    logic         sel;
    logic [31:0]  a0, d0, a1, d1;
    logic         e_err, e_hold;
    logic [15:0]  e_ww;
  } vec_t;
  vec_t vecs[10];

  // Packet-level reference state for the random phase.
  logic        m_err, m_hold;
  logic [15:0] m_ww;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  cmd, bb;
    logic [31:0] addr, word;
    int          cnt, kind, gap;
    logic [7:0]  pk[$];

    vecs[0] = '{"load_inst", 15, 128'h01_00_00_00_00_02_00_13_00_00_00_93_00_10_00_00, 2, 1'b0,
                32'h0, 32'h00000013, 32'h4, 32'h00100093, 1'b0, 1'b1, 16'd2};
    vecs[1] = '{"load_data", 11, 128'h02_04_10_00_00_01_00_EF_BE_AD_DE_00_00_00_00_00, 1, 1'b1,
                32'h00001004, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b1, 16'd1};
    vecs[2] = '{"run", 1, 128'h03_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 0, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd1};
    vecs[3] = '{"misaligned", 7, 128'h01_02_00_00_00_01_00_00_00_00_00_00_00_00_00_00, 0, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 16'd0};
    vecs[4] = '{"clear", 1, 128'h00_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 0, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 16'd0};
    vecs[5] = '{"unknown_cmd", 1, 128'h7F_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 0, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 16'd0};
    vecs[6] = '{"clear2", 1, 128'h00_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 0, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 16'd0};
    vecs[7] = '{"count_zero", 7, 128'h02_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, 0, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 16'd0};
    vecs[8] = '{"addr_wrap", 15, 128'h01_FC_FF_FF_FF_02_00_11_22_33_44_55_66_77_88_00, 2, 1'b0,
                32'hFFFFFFFC, 32'h44332211, 32'h00000000, 32'h88776655, 1'b0, 1'b1, 16'd2};
    vecs[9] = '{"count_4097", 7, 128'h01_00_00_00_00_01_10_00_00_00_00_00_00_00_00_00, 0, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 16'd0};

    // Reset state while reset is held.
    #12;
    chk("rst.in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst.core_hold", {31'd0, core_hold}, 32'd1);
    chk("rst.busy",      {31'd0, busy},      32'd0);
    chk("rst.err",       {31'd0, err},       32'd0);
    chk("rst.words",     {16'd0, words_written}, 32'd0);
    chk("rst.we",        {24'd0, inst_we2, data_we2}, 32'd0);
    chk("rst.inst_a2",   inst_a2, 32'd0);
    chk("rst.data_wd2",  data_wd2, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("idle.in_ready", {31'd0, in_ready},  32'd1);
    chk("idle.core_hold", {31'd0, core_hold}, 32'd1);
    wlog.delete();

    // Table-driven vectors; state carries over from one entry to the next.
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        bb = vecs[v].b[127 - 8*i -: 8];
        send_byte(bb, 0);
      end
      if (vecs[v].nw > 0) exp_q.push_back('{vecs[v].sel, 4'hF, vecs[v].a0, vecs[v].d0});
      if (vecs[v].nw > 1) exp_q.push_back('{vecs[v].sel, 4'hF, vecs[v].a1, vecs[v].d1});
      compare_state(vecs[v].name, vecs[v].e_err, vecs[v].e_hold, vecs[v].e_ww);
    end

    // Largest legal count: MAX_WORDS words must be accepted and all written.
    send_byte(8'h00, 0);
    pk = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
    foreach (pk[i]) send_byte(pk[i], 0);
    @(negedge clk);
    chk("max_count.busy", {31'd0, busy}, 32'd1);
    chk("max_count.err",  {31'd0, err},  32'd0);
    for (int w = 0; w < MAXW; w++) begin
      word = {w[15:0], ~w[15:0]};
      for (int j = 0; j < 4; j++) send_byte(word[8*j +: 8], 0);
      exp_q.push_back('{1'b1, 4'hF, 32'(4*w), word});
    end
    compare_state("max_count", 1'b0, 1'b1, 16'd4096);

    // in_valid low in the middle of a word stalls without writing.
    pk = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hA1, 8'hB2};
    foreach (pk[i]) send_byte(pk[i], 0);
    repeat (40) @(negedge clk);
    chk("stall.busy",    {31'd0, busy}, 32'd1);
    chk("stall.nwrites", wlog.size(), 32'd0);
    send_byte(8'hC3, 0);
    send_byte(8'hD4, 0);
    exp_q.push_back('{1'b0, 4'hF, 32'h00000100, 32'hD4C3B2A1});
    compare_state("stall", 1'b0, 1'b1, 16'd1);

    // Asynchronous reset mid-command.
    send_byte(8'h7F, 0);
    pk = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'hAA, 8'hBB};
    foreach (pk[i]) send_byte(pk[i], 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst.busy",      {31'd0, busy},      32'd0);
    chk("midrst.err",       {31'd0, err},       32'd0);
    chk("midrst.core_hold", {31'd0, core_hold}, 32'd1);
    chk("midrst.in_ready",  {31'd0, in_ready},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.in_ready_after", {31'd0, in_ready}, 32'd1);
    wlog.delete();
    pk = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    foreach (pk[i]) send_byte(pk[i], 0);
    exp_q.push_back('{1'b0, 4'hF, 32'h00000008, 32'h12345678});
    compare_state("after_midrst", 1'b0, 1'b1, 16'd1);

`ifdef LOADER_VERIFY_EN
    // Corrupted readback aborts after the first word with err set.
    corrupt = 1'b1;
    pk = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    foreach (pk[i]) send_byte(pk[i], 0);
    exp_q.push_back('{1'b0, 4'hF, 32'h00000200, 32'h04030201});
    compare_state("verify_corrupt", 1'b1, 1'b1, 16'd1);
    corrupt = 1'b0;
    send_byte(8'h00, 0);
    compare_state("verify_clear", 1'b0, 1'b1, 16'd1);
`endif

    // Randomized packets against the packet-level model.
    m_err = 1'b0;
    m_hold = 1'b1;
    m_ww = 16'd1;
    for (int p = 0; p < 60; p++) begin
      pk.delete();
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        pk.push_back(8'h00);
        m_err = 1'b0;
      end else if (kind == 1) begin
        pk.push_back(8'h03);
        m_hold = 1'b0;
      end else if (kind == 2) begin
        cmd = 8'($urandom_range(4, 255));
        pk.push_back(cmd);
        m_err = 1'b1;
      end else begin
        cmd  = 8'($urandom_range(1, 2));
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
        if ($urandom_range(0, 4) == 0) addr[31:4] = 28'hFFFFFFF;
        kind = $urandom_range(0, 9);
        if (kind == 0)      cnt = 0;
        else if (kind == 9) cnt = 4097 + $urandom_range(0, 1000);
        else                cnt = $urandom_range(1, 6);
        pk.push_back(cmd);
        for (int j = 0; j < 4; j++) pk.push_back(addr[8*j +: 8]);
        pk.push_back(8'(cnt));
        pk.push_back(8'(cnt >> 8));
        m_hold = 1'b1;
        m_ww = 16'd0;
        if (addr % 4 != 0 || cnt > MAXW) begin
          m_err = 1'b1;
        end else begin
          for (int w = 0; w < cnt; w++) begin
            word = $urandom;
            for (int j = 0; j < 4; j++) pk.push_back(word[8*j +: 8]);
            exp_q.push_back('{cmd == 8'h02, 4'hF, addr + 32'(4*w), word});
          end
          m_ww = 16'(cnt);
        end
      end
      foreach (pk[i]) begin
        gap = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
        send_byte(pk[i], gap);
      end
      compare_state($sformatf("rand%0d_cmd%02h", p, pk[0]), m_err, m_hold, m_ww);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32_debug_loader.md
Name: rv32_debug_loader

Overview:
- Upstream boot/debug loader for the RV32 pipelined core.
- Consumes a byte stream from a host link (UART receiver or testbench) and decodes load/run commands.
- Writes words into instruction RAM or data RAM through the core's debug second ports (A2/WD2/WE2/RD2).
- Holds the core in reset via core_hold until a RUN command is accepted.

Parameters:
- MAX_WORDS, 4096: largest accepted word count per load command; a larger count is an error.
- ADDR_W, 32: width of the debug byte address.

Ports:
- CPU_CLK  input  1  clock; all state updates on the rising edge.
- CPU_RST  input  1  asynchronous reset, active-high.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts a byte; a transfer happens when in_valid && in_ready on a clock edge.
- inst_a2  output  ADDR_W  instruction RAM debug byte address.
- inst_wd2  output  32  instruction RAM debug write data.
- inst_we2  output  4  instruction RAM debug byte write enables.
- inst_rd2  input  32  instruction RAM debug read data, 1-cycle synchronous.
- data_a2  output  ADDR_W  data RAM debug byte address.
- data_wd2  output  32  data RAM debug write data.
- data_we2  output  4  data RAM debug byte write enables.
- data_rd2  input  32  data RAM debug read data, 1-cycle synchronous.
- core_hold  output  1  OR'd into the core reset; 1 holds the core in reset.
- busy  output  1  a load command is in progress.
- err  output  1  sticky error flag.
- words_written  output  16  words written by the last load command.

Behaviour:
- Reset values: in_ready=0, all A2/WD2=0, all WE2=0, core_hold=1, busy=0, err=0, words_written=0, state=CMD. in_ready rises on the first clock edge after reset deasserts.
- Reset mid-operation aborts the command at once. Partial writes already in RAM stay; no recovery is attempted.
- Packet format: CMD byte, then for load commands 4 address bytes (little-endian), 2 count bytes (little-endian), then count*4 data bytes (little-endian per word).
- Commands:
  - 0x01 load instruction RAM.
  - 0x02 load data RAM.
  - 0x03 run: core_hold goes to 0 on the next edge.
  - 0x00 clear: err goes to 0.
  - Any other value sets err=1 and returns to CMD.
- Accepting a load command sets core_hold=1 and busy=1. words_written resets to 0.
- States:
  - CMD → ADDR (4 bytes) → LEN (2 bytes).
  - LEN → DATA when count ≠ 0.
  - LEN → CMD when count = 0, with no writes and busy dropping to 0.
  - DATA collects 4 bytes → WRITE.
  - WRITE: one cycle with the selected port's WE2=4'hF, A2=base+4*i, WD2=assembled word; all other cycles WE2=0. Then → VERIFY when LOADER_VERIFY_EN is defined, else → DATA, or → CMD after the last word.
- in_ready=1 in CMD, ADDR, LEN and DATA; in_ready=0 in WRITE and VERIFY. Per-word throughput is 4 byte cycles plus 1 write cycle (plus 2 verify cycles if enabled).
- Errors detected at the end of LEN:
  - address[1:0] ≠ 0 → err=1, return to CMD with no writes.
  - count > MAX_WORDS → err=1, return to CMD with no writes.
- err is sticky. It is cleared only by reset or the 0x00 command. Commands are still processed while err=1.
- Address arithmetic is modulo 2^ADDR_W; base+4*i wraps silently.
- words_written increments on each WRITE cycle and saturates at 16'hFFFF.
- in_valid low during DATA stalls the FSM indefinitely. There is no timeout.
- The unselected RAM port is held at WE2=0.

Optional Feature:
- LOADER_VERIFY_EN defined:
  - After each WRITE, the loader holds A2 for one cycle with WE2=0.
  - The next cycle it compares the selected rd2 with the written word.
  - On mismatch, err=1 and the command aborts to CMD; words_written keeps its count, including the failed word.
- Undefined: no readback. rd2 inputs are unused and WRITE goes straight to DATA/CMD.

Test Plan:
- Reset then idle → core_hold=1, in_ready=1, err=0, all WE2=0.
- Stream 01 00 00 00 00 02 00 13 00 00 00 93 00 10 00 → inst_we2=F at addr 0x0 with 0x00000013, then at addr 0x4 with 0x00100093; words_written=2, busy=0, data_we2 always 0.
- Stream 02 04 10 00 00 01 00 EF BE AD DE, then 03 → data write 0xDEADBEEF at 0x00001004; core_hold falls one cycle after the 03 byte transfers.
- Misaligned header 01 02 00 00 00 01 00 → err=1, no WE2 pulse. Then 00 → err=0.
- Unknown command 0x7F → err=1. Count 0 load → no writes, busy returns to 0. Address 0xFFFFFFFC with count 2 → second write at 0x00000000.
- With LOADER_VERIFY_EN and a bench RAM model that corrupts rd2 → err=1 after the first word, FSM back in CMD, in_ready=1.
